ariane_regfile_scrub_ff: RTL and testbench
==========================================

// Module: ariane_regfile_scrub_ff
// PURPOSE
//   Flop-based integer/FP register file for the issue/commit path; successor of the fixed
//   32-entry regfile, generalised in depth, width and read/write port count.
//   Adds deterministic write-collision priority, a collision flag and a sequential
//   scrub (clear) engine that zeroes the array one entry per cycle.
//   Reads feed operand fetch; writes come from the commit ports.
// PARAMETERS
//   DATA_WIDTH      64   bits per register
//   NR_REGS         32   number of registers (>=2); ADDR_W = $clog2(NR_REGS)
//   NR_READ_PORTS   2    combinational read ports
//   NR_WRITE_PORTS  2    synchronous write ports
//   ZERO_REG_ZERO   1    1: register 0 hard-wired to zero (writes dropped, reads 0)
// PORTS
//   clk_i          in   1                          clock, rising edge
//   rst_ni         in   1                          asynchronous reset, active low
//   test_en_i      in   1                          DFT enable; no functional effect
//   raddr_i        in   NR_READ_PORTS x ADDR_W     read addresses
//   rdata_o        out  NR_READ_PORTS x DATA_WIDTH read data
//   waddr_i        in   NR_WRITE_PORTS x ADDR_W    write addresses
//   wdata_i        in   NR_WRITE_PORTS x DATA_WIDTH write data
//   we_i           in   NR_WRITE_PORTS             per-port write enable
//   clear_req_i    in   1                          start scrub (sampled in IDLE only)
//   clear_busy_o   out  1                          scrub in progress; writes ignored
//   clear_done_o   out  1                          1-cycle pulse at end of scrub
//   wr_conflict_o  out  1                          1-cycle pulse, cycle after a collision
// BEHAVIOUR
//   Reset: async, rst_ni=0 -> all registers 0, FSM IDLE, pointer 0,
//     clear_busy_o=0, clear_done_o=0, wr_conflict_o=0; rdata_o reads 0 from reset state.
//   Read: rdata_o[r] combinational from array, zero latency.
//     ZERO_REG_ZERO=1 and raddr=0 -> 0. raddr >= NR_REGS -> 0.
//   Write: commits on rising edge when we_i[p]=1 and FSM is IDLE; visible next cycle.
//     Writes to reg 0 are dropped when ZERO_REG_ZERO=1; waddr >= NR_REGS is dropped.
//     Several enabled ports with the same waddr: highest port index wins.
//     Collision (>=2 enabled ports, same in-range waddr, incl. reg 0) -> wr_conflict_o=1
//     in the next cycle only; registered; a collision in cycle N gives a pulse in N+1.
//   Scrub FSM: IDLE -> CLEAR -> DONE -> IDLE.
//     IDLE:  clear_req_i=1 -> CLEAR, ptr<=0. Writes in the same cycle still commit.
//     CLEAR: clear_busy_o=1; each cycle reg[ptr]<=0, ptr<=ptr+1; all we_i ignored.
//            ptr==NR_REGS-1 -> DONE (last entry cleared that edge); no wrap past NR_REGS-1.
//     DONE:  clear_done_o=1, clear_busy_o=0, writes accepted again -> IDLE.
//     Scrub length: NR_REGS cycles busy + 1 cycle done.
//     clear_req_i outside IDLE is ignored (not queued). Held high -> rescrub after DONE.
//     Reads during CLEAR return current contents: entries < ptr read 0, the rest keep
//     their old values.
//     wr_conflict_o is not raised while in CLEAR (writes ignored).
//   Reset mid-scrub: array zeroed, FSM IDLE, no clear_done_o pulse.
// CONFIGURATION
//   ARIANE_REGFILE_BYPASS_EN defined: write-to-read forwarding.
//     If raddr_i[r] equals the waddr of an accepted write in the same cycle, rdata_o[r]
//     = wdata of the highest-index matching port (combinational). Same rules as writes:
//     none in CLEAR, none for reg 0 with ZERO_REG_ZERO=1, none for out-of-range.
//   Undefined: no forwarding; reads return the stored value, new data next cycle.
// TESTING
//   T1 reset: rst_ni=0 mid-traffic -> every rdata_o 0, all status outputs 0 asynchronously.
//   T2 write/read: we_i=2'b01, waddr[0]=5, wdata[0]=64'hA5 -> raddr=5 reads 64'hA5
//      next cycle; bypass build: same cycle.
//      Undefined build, same cycle: old value.
//   T3 collision: both ports waddr=7, wdata 64'h11/64'h22
//      -> reg7=64'h22, wr_conflict_o=1 next cycle only.
//   T4 zero reg: ZERO_REG_ZERO=1, write 64'hFF to reg 0 -> reads 0, no bypass.
//      ZERO_REG_ZERO=0 -> reads 64'hFF.
//   T5 scrub: fill regs with index value, pulse clear_req_i
//      -> clear_busy_o high exactly NR_REGS cycles.
//      Reg k reads 0 from busy cycle k+1; we_i during busy ignored.
//      clear_done_o pulses once; a write in the DONE cycle commits.
//   T6 reset mid-scrub: rst_ni=0 at busy cycle 10 -> IDLE, all zero, no clear_done_o;
//      new clear_req_i restarts from ptr=0.

Source files
------------

// File: rtl/ariane_regfile_scrub_ff.sv
// ---------------------------------------------------------------------------
// ariane_regfile_scrub_ff
//
// Flop-based integer/FP register file for the issue/commit path. Depth,
// width and the number of read/write ports are parameterised. Adds
// deterministic write-collision priority (highest port index wins), a
// registered collision flag and a sequential scrub engine that zeroes the
// array one entry per cycle.
//
// Build option:
//   ARIANE_REGFILE_BYPASS_EN  defined   -> accepted writes are forwarded
//                                          combinationally to matching reads
//                             undefined -> reads return stored contents only
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous reset, active low
//   test_en_i      DFT enable, no functional effect
//   raddr_i        read addresses, one per read port
//   rdata_o        read data, combinational, one per read port
//   waddr_i        write addresses, one per write port
//   wdata_i        write data, one per write port
//   we_i           per-port write enable
//   clear_req_i    start a scrub (only honoured while idle)
//   clear_busy_o   scrub in progress; writes are ignored
//   clear_done_o   one-cycle pulse after the last entry has been cleared
//   wr_conflict_o  one-cycle pulse, the cycle after a write collision
// ---------------------------------------------------------------------------
module ariane_regfile_scrub_ff #(
    parameter int unsigned  DATA_WIDTH     = 64,
    parameter int unsigned  NR_REGS        = 32,
    parameter int unsigned  NR_READ_PORTS  = 2,
    parameter int unsigned  NR_WRITE_PORTS = 2,
    parameter int unsigned  ZERO_REG_ZERO  = 1,
    localparam int unsigned ADDR_W         = $clog2(NR_REGS)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      test_en_i,
    input  logic [NR_READ_PORTS-1:0][ADDR_W-1:0]      raddr_i,
    output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
    input  logic [NR_WRITE_PORTS-1:0][ADDR_W-1:0]     waddr_i,
    input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
    input  logic [NR_WRITE_PORTS-1:0]                 we_i,
    input  logic                                      clear_req_i,
    output logic                                      clear_busy_o,
    output logic                                      clear_done_o,
    output logic                                      wr_conflict_o
);

    // One extra bit so non-power-of-two depths can be range checked.
    localparam logic [ADDR_W:0]   REGS_BOUND = (ADDR_W + 1)'(NR_REGS);
    localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(NR_REGS - 1);
    localparam bit                ZERO_REG   = (ZERO_REG_ZERO != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [ADDR_W-1:0]          ptr_q, ptr_d;

    logic [DATA_WIDTH-1:0]      mem_q [NR_REGS];
    logic [DATA_WIDTH-1:0]      mem_d [NR_REGS];

    logic                       write_open;
    logic [NR_WRITE_PORTS-1:0]  waddr_valid;
    logic [NR_WRITE_PORTS-1:0]  wr_accept;
    logic                       conflict_d, conflict_q;

    logic                       unused_test_en;
    assign unused_test_en = test_en_i;

    // -----------------------------------------------------------------------
    // Write qualification: writes are open in IDLE and DONE, never in CLEAR.
    // A write is accepted only for an in-range address that is not the
    // hard-wired zero register.
    // -----------------------------------------------------------------------
    always_comb begin
        write_open  = (state_q != ST_CLEAR);
        waddr_valid = '0;
        wr_accept   = '0;
        for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
            waddr_valid[p] = ({1'b0, waddr_i[p]} < REGS_BOUND);
            wr_accept[p]   = write_open && we_i[p] && waddr_valid[p] &&
                             !(ZERO_REG && (waddr_i[p] == '0));
        end
    end

    // -----------------------------------------------------------------------
    // Collision detect: two or more enabled ports on the same in-range
    // address. Register 0 still counts even though its writes are dropped.
    // -----------------------------------------------------------------------
    always_comb begin
        conflict_d = 1'b0;
        for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
            for (int unsigned q = p + 1; q < NR_WRITE_PORTS; q++) begin
                if (write_open && we_i[p] && we_i[q] && waddr_valid[p] &&
                    (waddr_i[p] == waddr_i[q])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign wr_conflict_o = conflict_q;

    // -----------------------------------------------------------------------
    // Array next value. Ports are applied in ascending order so the highest
    // enabled port index overwrites lower ones on a shared address.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_d = mem_q;
        if (state_q == ST_CLEAR) begin
            mem_d[ptr_q] = '0;
        end else begin
            for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
                if (wr_accept[p]) begin
                    mem_d[waddr_i[p]] = wdata_i[p];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // -----------------------------------------------------------------------
    // Scrub FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Scrub FSM: next state. The pointer stops at the last entry; the edge
    // that leaves CLEAR is the one that clears that entry.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_req_i) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_DONE;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Scrub FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        clear_busy_o = 1'b0;
        clear_done_o = 1'b0;
        unique case (state_q)
            ST_CLEAR: clear_busy_o = 1'b1;
            ST_DONE:  clear_done_o = 1'b1;
            default: begin
                clear_busy_o = 1'b0;
                clear_done_o = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Read ports: out-of-range and the hard-wired zero register read 0.
    // With forwarding, an accepted same-cycle write to the read address
    // overrides the stored value; wr_accept already excludes CLEAR, reg 0
    // and out-of-range addresses.
    // -----------------------------------------------------------------------
    always_comb begin
        rdata_o = '0;
        for (int unsigned r = 0; r < NR_READ_PORTS; r++) begin
            if (({1'b0, raddr_i[r]} < REGS_BOUND) &&
                !(ZERO_REG && (raddr_i[r] == '0))) begin
                rdata_o[r] = mem_q[raddr_i[r]];
            end
`ifdef ARIANE_REGFILE_BYPASS_EN
            for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
                if (wr_accept[p] && (waddr_i[p] == raddr_i[r])) begin
                    rdata_o[r] = wdata_i[p];
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_ariane_regfile_scrub_ff.sv
`timescale 1ns/1ps
module tb_ariane_regfile_scrub_ff;

    localparam int DW  = 64;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int DWB = 16;
    localparam int NRB = 24;
    localparam int AWB = 5;

`ifdef ARIANE_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic test_en;

    // Instance A: default configuration
    logic [1:0][AW-1:0] raddr;
    logic [1:0][DW-1:0] rdata;
    logic [1:0][AW-1:0] waddr;
    logic [1:0][DW-1:0] wdata;
    logic [1:0]         we;
    logic               clear_req, clear_busy, clear_done, wr_conflict;

    // Instance B: 24 entries, register 0 writable, 16-bit data
    logic [1:0][AWB-1:0] raddr_b;
    logic [1:0][DWB-1:0] rdata_b;
    logic [1:0][AWB-1:0] waddr_b;
    logic [1:0][DWB-1:0] wdata_b;
    logic [1:0]          we_b;
    logic                clear_req_b, clear_busy_b, clear_done_b, wr_conflict_b;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0]  ref_a [NR];
    logic [DWB-1:0] ref_b [NRB];
    bit             exp_conflict;
    bit             exp_conflict_b;

    ariane_regfile_scrub_ff u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .test_en_i     (test_en),
        .raddr_i       (raddr),
        .rdata_o       (rdata),
        .waddr_i       (waddr),
        .wdata_i       (wdata),
        .we_i          (we),
        .clear_req_i   (clear_req),
        .clear_busy_o  (clear_busy),
        .clear_done_o  (clear_done),
        .wr_conflict_o (wr_conflict)
    );

    ariane_regfile_scrub_ff #(
        .DATA_WIDTH     (DWB),
        .NR_REGS        (NRB),
        .NR_READ_PORTS  (2),
        .NR_WRITE_PORTS (2),
        .ZERO_REG_ZERO  (0)
    ) u_dut_b (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .test_en_i     (test_en),
        .raddr_i       (raddr_b),
        .rdata_o       (rdata_b),
        .waddr_i       (waddr_b),
        .wdata_i       (wdata_b),
        .we_i          (we_b),
        .clear_req_i   (clear_req_b),
        .clear_busy_o  (clear_busy_b),
        .clear_done_o  (clear_done_b),
        .wr_conflict_o (wr_conflict_b)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] model_read_a(input logic [AW-1:0] a, input bit open);
        logic [DW-1:0] v;
        if (a == '0) return '0;
        v = ref_a[a];
        if (BYPASS && open)
            for (int p = 0; p < 2; p++)
                if (we[p] && waddr[p] == a) v = wdata[p];
        return v;
    endfunction

    function automatic logic [DWB-1:0] model_read_b(input logic [AWB-1:0] a);
        logic [DWB-1:0] v;
        if (int'(a) >= NRB) return '0;
        v = ref_b[a];
        if (BYPASS)
            for (int p = 0; p < 2; p++)
                if (we_b[p] && waddr_b[p] == a) v = wdata_b[p];
        return v;
    endfunction

    task automatic clear_refs();
        for (int i = 0; i < NR; i++) ref_a[i] = '0;
        for (int i = 0; i < NRB; i++) ref_b[i] = '0;
        exp_conflict   = 1'b0;
        exp_conflict_b = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply the current cycle's writes to the model, then advance one clock.
    task automatic finish_cycle(input bit open_a, input bit open_b);
        if (open_a)
            for (int p = 0; p < 2; p++)
                if (we[p] && waddr[p] != '0) ref_a[waddr[p]] = wdata[p];
        if (open_b)
            for (int p = 0; p < 2; p++)
                if (we_b[p] && int'(waddr_b[p]) < NRB) ref_b[waddr_b[p]] = wdata_b[p];
        exp_conflict   = open_a && we == 2'b11 && waddr[0] == waddr[1];
        exp_conflict_b = open_b && we_b == 2'b11 && waddr_b[0] == waddr_b[1] &&
                         int'(waddr_b[0]) < NRB;
        tick();
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom} | 64'h1;
    endfunction

    task automatic fill_regs(input int base);
        for (int i = 0; i < NR; i += 2) begin
            we = 2'b11;
            waddr[0] = AW'(i);     wdata[0] = DW'(i + base);
            waddr[1] = AW'(i + 1); wdata[1] = DW'(i + 1 + base);
            #1;
            finish_cycle(1, 1);
        end
        we = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            raddr[0] = AW'($urandom_range(0, NR - 1));
            raddr[1] = AW'($urandom_range(0, NR - 1));
            raddr_b[0] = AWB'($urandom_range(0, NRB - 1));
            raddr_b[1] = AWB'($urandom_range(0, NRB - 1));
            #1;
            tests++; if (rdata !== '0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
            tests++; if (rdata_b !== '0) begin fails++; $display("FAIL reset_rdata_b: got %h expected 0", rdata_b); end
        end
        tests++;
        if ({clear_busy, clear_done, wr_conflict} !== 3'b000) begin
            fails++; $display("FAIL reset_status: busy/done/conflict=%b expected 000", {clear_busy, clear_done, wr_conflict});
        end
        tick();
        rst_n = 1'b1;
        clear_refs();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] exp;
        we = 2'b01; waddr[0] = 5'd5; wdata[0] = 64'hA5;
        waddr[1] = 5'd9; wdata[1] = rnd64();
        raddr[0] = 5'd5; raddr[1] = 5'd9;
        #1;
        exp = BYPASS ? 64'hA5 : ref_a[5];
        tests++; if (rdata[0] !== exp) begin fails++; $display("FAIL wr_same_cycle: got %h expected %h", rdata[0], exp); end
        finish_cycle(1, 1);
        we = '0;
        #1;
        tests++; if (rdata[0] !== 64'hA5) begin fails++; $display("FAIL wr_next_cycle: got %h expected %h", rdata[0], 64'hA5); end
        tests++; if (rdata[1] !== ref_a[9]) begin fails++; $display("FAIL wr_disabled_port: got %h expected %h", rdata[1], ref_a[9]); end
        finish_cycle(1, 1);
    endtask

    task automatic test_collision();
        logic [DW-1:0] exp;
        we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7;
        wdata[0] = 64'h11; wdata[1] = 64'h22; raddr[0] = 5'd7; raddr[1] = 5'd0;
        #1;
        exp = model_read_a(5'd7, 1);
        tests++; if (rdata[0] !== exp) begin fails++; $display("FAIL coll_same_cycle: got %h expected %h", rdata[0], exp); end
        tests++; if (wr_conflict !== 1'b0) begin fails++; $display("FAIL coll_early: got %b expected 0", wr_conflict); end
        finish_cycle(1, 1);
        we = '0;
        #1;
        tests++; if (rdata[0] !== 64'h22) begin fails++; $display("FAIL coll_winner: got %h expected %h", rdata[0], 64'h22); end
        tests++; if (wr_conflict !== 1'b1) begin fails++; $display("FAIL coll_pulse: got %b expected 1", wr_conflict); end
        finish_cycle(1, 1);
        tests++; if (wr_conflict !== 1'b0) begin fails++; $display("FAIL coll_pulse_len: got %b expected 0", wr_conflict); end
    endtask

    task automatic test_zero_reg();
        we = 2'b10; waddr[1] = 5'd0; wdata[1] = 64'hFF; raddr[0] = 5'd0;
        #1;
        tests++; if (rdata[0] !== '0) begin fails++; $display("FAIL zero_bypass: got %h expected 0", rdata[0]); end
        finish_cycle(1, 1);
        we = 2'b11; waddr[0] = 5'd0; waddr[1] = 5'd0;
        #1;
        tests++; if (rdata[0] !== '0) begin fails++; $display("FAIL zero_stored: got %h expected 0", rdata[0]); end
        finish_cycle(1, 1);
        we = '0;
        #1;
        tests++; if (wr_conflict !== 1'b1) begin fails++; $display("FAIL zero_collision: got %b expected 1", wr_conflict); end
        finish_cycle(1, 1);
    endtask

    task automatic test_random(input int n);
        logic [DW-1:0] exp;
        for (int c = 0; c < n; c++) begin
            we = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                waddr[p] = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NR - 1));
                wdata[p] = rnd64();
            end
            for (int r = 0; r < 2; r++)
                raddr[r] = $urandom_range(0, 1) ? waddr[$urandom_range(0, 1)] : AW'($urandom_range(0, NR - 1));
            #1;
            for (int r = 0; r < 2; r++) begin
                exp = model_read_a(raddr[r], 1);
                tests++;
                if (rdata[r] !== exp) begin
                    fails++; $display("FAIL rand_read c=%0d r=%0d addr=%0d: got %h expected %h", c, r, raddr[r], rdata[r], exp);
                end
            end
            tests++;
            if (wr_conflict !== exp_conflict) begin
                fails++; $display("FAIL rand_conflict c=%0d: got %b expected %b", c, wr_conflict, exp_conflict);
            end
            finish_cycle(1, 1);
        end
        we = '0;
    endtask

    task automatic test_scrub();
        logic [DW-1:0] snap [NR];
        logic [DW-1:0] exp;
        int j;
        fill_regs(0);
        // request cycle: a simultaneous write still commits
        clear_req = 1'b1; we = 2'b01; waddr[0] = 5'd3; wdata[0] = 64'h333;
        #1;
        tests++; if (clear_busy !== 1'b0) begin fails++; $display("FAIL scrub_req_busy: got %b expected 0", clear_busy); end
        finish_cycle(1, 1);
        for (int i = 0; i < NR; i++) snap[i] = ref_a[i];
        for (int k = 0; k < NR; k++) begin
            clear_req = (k > 0 && k < NR - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            we = 2'($urandom_range(0, 3));
            waddr[0] = AW'($urandom_range(0, NR - 1));
            waddr[1] = $urandom_range(0, 1) ? waddr[0] : AW'($urandom_range(0, NR - 1));
            wdata[0] = rnd64(); wdata[1] = rnd64();
            j = (k > 0 && $urandom_range(0, 1) == 1) ? k - 1 : $urandom_range(0, NR - 1);
            raddr[0] = AW'(k); raddr[1] = AW'(j);
            #1;
            tests++; if (clear_busy !== 1'b1) begin fails++; $display("FAIL scrub_busy k=%0d: got %b expected 1", k, clear_busy); end
            tests++; if (clear_done !== 1'b0) begin fails++; $display("FAIL scrub_done_early k=%0d: got %b expected 0", k, clear_done); end
            tests++; if (wr_conflict !== 1'b0) begin fails++; $display("FAIL scrub_conflict k=%0d: got %b expected 0", k, wr_conflict); end
            tests++; if (rdata[0] !== snap[k]) begin fails++; $display("FAIL scrub_cur k=%0d: got %h expected %h", k, rdata[0], snap[k]); end
            exp = (j < k) ? '0 : snap[j];
            tests++; if (rdata[1] !== exp) begin fails++; $display("FAIL scrub_other k=%0d j=%0d: got %h expected %h", k, j, rdata[1], exp); end
            tick();
        end
        clear_refs();
        // DONE cycle: write is accepted
        clear_req = 1'b0; we = 2'b01; waddr[0] = 5'd9; wdata[0] = 64'h99;
        raddr[0] = 5'd9; raddr[1] = 5'd3;
        #1;
        tests++; if ({clear_busy, clear_done} !== 2'b01) begin fails++; $display("FAIL scrub_done: busy/done=%b expected 01", {clear_busy, clear_done}); end
        exp = BYPASS ? 64'h99 : '0;
        tests++; if (rdata[0] !== exp) begin fails++; $display("FAIL done_bypass: got %h expected %h", rdata[0], exp); end
        tests++; if (rdata[1] !== '0) begin fails++; $display("FAIL scrub_reg3: got %h expected 0", rdata[1]); end
        finish_cycle(1, 1);
        we = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++; if ({clear_busy, clear_done} !== 2'b00) begin fails++; $display("FAIL scrub_after c=%0d: busy/done=%b expected 00", c, {clear_busy, clear_done}); end
            tests++; if (rdata[0] !== 64'h99) begin fails++; $display("FAIL done_write c=%0d: got %h expected %h", c, rdata[0], 64'h99); end
            finish_cycle(1, 1);
        end
    endtask

    task automatic test_rescrub_held();
        bit eb, ed;
        we = '0;
        for (int c = 0; c < 70; c++) begin
            clear_req = (c <= 34);
            #1;
            eb = (c >= 1 && c <= 32) || (c >= 35 && c <= 66);
            ed = (c == 33) || (c == 67);
            tests++;
            if ({clear_busy, clear_done} !== {eb, ed}) begin
                fails++; $display("FAIL rescrub c=%0d: busy/done=%b expected %b", c, {clear_busy, clear_done}, {eb, ed});
            end
            finish_cycle(0, 1);
        end
        clear_req = 1'b0;
        clear_refs();
    endtask

    task automatic test_reset_mid_traffic();
        we = 2'b11; waddr[0] = 5'd12; waddr[1] = 5'd12;
        wdata[0] = rnd64(); wdata[1] = rnd64(); raddr[0] = 5'd12; raddr[1] = 5'd0;
        #1;
        finish_cycle(1, 1);
        we = '0;
        #1;
        tests++; if (wr_conflict !== 1'b1) begin fails++; $display("FAIL mid_pre_conflict: got %b expected 1", wr_conflict); end
        tests++; if (rdata[0] !== ref_a[12]) begin fails++; $display("FAIL mid_pre_data: got %h expected %h", rdata[0], ref_a[12]); end
        #1; rst_n = 1'b0; #1;
        tests++; if (rdata[0] !== '0) begin fails++; $display("FAIL mid_async_data: got %h expected 0", rdata[0]); end
        tests++;
        if ({clear_busy, clear_done, wr_conflict} !== 3'b000) begin
            fails++; $display("FAIL mid_async_status: busy/done/conflict=%b expected 000", {clear_busy, clear_done, wr_conflict});
        end
        tick();
        rst_n = 1'b1;
        clear_refs();
    endtask

    task automatic test_reset_mid_scrub();
        int a;
        fill_regs(256);
        clear_req = 1'b1;
        #1;
        finish_cycle(1, 1);
        clear_req = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        a = $urandom_range(11, NR - 1);
        raddr[0] = AW'(a); raddr[1] = 5'd1;
        #1;
        tests++; if (rdata[0] !== ref_a[a]) begin fails++; $display("FAIL rms_pre a=%0d: got %h expected %h", a, rdata[0], ref_a[a]); end
        rst_n = 1'b0;
        #1;
        tests++; if (rdata !== '0) begin fails++; $display("FAIL rms_async_data: got %h expected 0", rdata); end
        tests++; if ({clear_busy, clear_done} !== 2'b00) begin fails++; $display("FAIL rms_async_status: busy/done=%b expected 00", {clear_busy, clear_done}); end
        tick();
        rst_n = 1'b1;
        clear_refs();
        for (int c = 0; c < NR + 3; c++) begin
            #1;
            tests++; if ({clear_busy, clear_done} !== 2'b00) begin fails++; $display("FAIL rms_no_done c=%0d: busy/done=%b expected 00", c, {clear_busy, clear_done}); end
            finish_cycle(1, 1);
        end
        we = 2'b11; waddr[0] = 5'd1; wdata[0] = 64'h1111; waddr[1] = 5'd20; wdata[1] = 64'h2020;
        #1;
        finish_cycle(1, 1);
        we = '0; clear_req = 1'b1;
        #1;
        finish_cycle(1, 1);
        clear_req = 1'b0;
        raddr[0] = 5'd1; raddr[1] = 5'd20;
        for (int k = 0; k < NR; k++) begin
            #1;
            tests++; if (clear_busy !== 1'b1) begin fails++; $display("FAIL rms_restart_busy k=%0d: got %b expected 1", k, clear_busy); end
            tests++;
            if (rdata[0] !== ((k > 1) ? 64'h0 : 64'h1111)) begin
                fails++; $display("FAIL rms_restart_r1 k=%0d: got %h expected %h", k, rdata[0], (k > 1) ? 64'h0 : 64'h1111);
            end
            tests++;
            if (rdata[1] !== ((k > 20) ? 64'h0 : 64'h2020)) begin
                fails++; $display("FAIL rms_restart_r20 k=%0d: got %h expected %h", k, rdata[1], (k > 20) ? 64'h0 : 64'h2020);
            end
            tick();
        end
        #1;
        tests++; if (clear_done !== 1'b1) begin fails++; $display("FAIL rms_restart_done: got %b expected 1", clear_done); end
        clear_refs();
        finish_cycle(1, 1);
    endtask

    task automatic test_b_zero_and_range();
        logic [DWB-1:0] exp;
        we_b = 2'b11; waddr_b[0] = 5'd0; wdata_b[0] = 16'h00FF; waddr_b[1] = 5'd3; wdata_b[1] = 16'h0303;
        raddr_b[0] = 5'd0; raddr_b[1] = 5'd3;
        #1;
        exp = model_read_b(5'd0);
        tests++; if (rdata_b[0] !== exp) begin fails++; $display("FAIL b_zero_same: got %h expected %h", rdata_b[0], exp); end
        finish_cycle(1, 1);
        we_b = 2'b11; waddr_b[0] = 5'd27; waddr_b[1] = 5'd27;
        wdata_b[0] = 16'hDEAD; wdata_b[1] = 16'hBEEF; raddr_b[0] = 5'd27; raddr_b[1] = 5'd0;
        #1;
        tests++; if (rdata_b[0] !== '0) begin fails++; $display("FAIL b_oor_bypass: got %h expected 0", rdata_b[0]); end
        tests++; if (rdata_b[1] !== 16'h00FF) begin fails++; $display("FAIL b_zero_writable: got %h expected 00ff", rdata_b[1]); end
        finish_cycle(1, 1);
        we_b = 2'b11; waddr_b[0] = 5'd23; waddr_b[1] = 5'd23;
        wdata_b[0] = 16'h1234; wdata_b[1] = 16'hABCD; raddr_b[0] = 5'd27; raddr_b[1] = 5'd3;
        #1;
        tests++; if (wr_conflict_b !== 1'b0) begin fails++; $display("FAIL b_oor_conflict: got %b expected 0", wr_conflict_b); end
        tests++; if (rdata_b[0] !== '0) begin fails++; $display("FAIL b_oor_read: got %h expected 0", rdata_b[0]); end
        tests++; if (rdata_b[1] !== 16'h0303) begin fails++; $display("FAIL b_oor_alias: got %h expected 0303", rdata_b[1]); end
        finish_cycle(1, 1);
        we_b = '0; raddr_b[0] = 5'd23;
        #1;
        tests++; if (wr_conflict_b !== exp_conflict_b) begin fails++; $display("FAIL b_last_conflict: got %b expected %b", wr_conflict_b, exp_conflict_b); end
        tests++; if (rdata_b[0] !== 16'hABCD) begin fails++; $display("FAIL b_last_reg: got %h expected abcd", rdata_b[0]); end
        finish_cycle(1, 1);
    endtask

    task automatic test_b_scrub_len();
        int busy_cnt = 0;
        int done_cnt = 0;
        clear_req_b = 1'b1;
        #1;
        finish_cycle(1, 1);
        clear_req_b = 1'b0;
        for (int c = 0; c < 60; c++) begin
            #1;
            busy_cnt += int'(clear_busy_b);
            done_cnt += int'(clear_done_b);
            finish_cycle(1, 0);
        end
        tests++; if (busy_cnt != NRB) begin fails++; $display("FAIL b_scrub_busy_len: got %0d expected %0d", busy_cnt, NRB); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL b_scrub_done_cnt: got %0d expected 1", done_cnt); end
        raddr_b[0] = 5'd23; raddr_b[1] = 5'd0;
        #1;
        tests++; if (rdata_b !== '0) begin fails++; $display("FAIL b_scrub_cleared: got %h expected 0", rdata_b); end
        clear_refs();
        finish_cycle(1, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_en = 1'b0;
        raddr = '0; waddr = '0; wdata = '0; we = '0; clear_req = 1'b0;
        raddr_b = '0; waddr_b = '0; wdata_b = '0; we_b = '0; clear_req_b = 1'b0;
        clear_refs();
        test_reset();
        test_write_read();
        test_collision();
        test_zero_reg();
        test_random(300);
        test_reset_mid_traffic();
        test_scrub();
        test_rescrub_held();
        test_reset_mid_scrub();
        test_b_zero_and_range();
        test_b_scrub_len();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
